ssd_bcd_display: RTL and testbench
==================================

SSD_BCD_DISPLAY -- requirements
Module: ssd_bcd_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of seven-segment digits driven (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of the binary input value (4..32).
REQ-003 SHALL have parameter BLINK_DIV, default 25_000_000: clk cycles per blink phase (half-period).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-005 SHALL have in_valid input 1: a new value is offered.
REQ-006 SHALL have in_ready output 1: the block can accept a value.
REQ-007 SHALL have in_data input DATA_WIDTH: the value to display.
REQ-008 SHALL have in_mode input 1: 0 = hexadecimal, 1 = decimal.
REQ-009 SHALL have in_signed input 1: decimal mode treats in_data as two's complement.
REQ-010 SHALL have blank_lz input 1: blank leading zeros.
REQ-011 SHALL have blink_en input 1: enable blinking of the whole display.
REQ-012 SHALL have ssd output 7*NUM_DIGITS: active-low segments; ssd[6:0] is digit 0 (rightmost); bit order within each digit is g,f,e,d,c,b,a (MSB to LSB).
REQ-013 SHALL have busy output 1: a decimal conversion is in progress.

Function
REQ-014 SHALL capture in_data, in_mode, in_signed and blank_lz on the clk edge where in_valid and in_ready are both 1; the inputs are sampled only at that edge.
REQ-015 SHALL drive in_ready = 1 only in IDLE; offers made while in_ready = 0 SHALL be held off, never dropped silently by the block.
REQ-016 SHALL implement the FSM states IDLE, LOAD, SHIFT and COMMIT: IDLE goes to LOAD on a decimal handshake; LOAD goes to SHIFT; SHIFT runs for exactly DATA_WIDTH cycles, then goes to COMMIT; COMMIT goes to IDLE.
REQ-017 SHALL drive busy = 1 in LOAD, SHIFT and COMMIT.
REQ-018 SHALL, in hex mode, update ssd on the edge after the handshake (latency 1) and remain in IDLE; digits above DATA_WIDTH/4 SHALL show 0.
REQ-019 SHALL, in decimal mode, convert with shift-add-3 (double dabble), one input bit per SHIFT cycle; ssd SHALL update exactly DATA_WIDTH+2 cycles after the handshake.
REQ-020 SHALL, in decimal mode with in_signed = 1 and MSB = 1, convert the magnitude (two's complement negation, DATA_WIDTH+1 bits internally so the most negative value is correct) and show "-" (segment g only) in the top digit.
REQ-021 SHALL show overflow as all digits "-" (7'h3F) when the value needs more than NUM_DIGITS decimal digits, or more than NUM_DIGITS-1 digits when negative.
REQ-022 SHALL, when blank_lz = 1, blank (7'h7F) every zero digit above the most significant nonzero digit; digit 0 SHALL always be shown; the minus sign stays in the top digit.
REQ-023 SHALL use glyphs 0-9 and A-F with standard encodings, e.g. 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 7 = 7'h78, A = 7'h08, F = 7'h0E.
REQ-024 SHALL hold the displayed value until the next committed update.
REQ-025 SHALL run the blink counter freely; with blink_en = 1, ssd SHALL be all 7'h7F during the off phase, and the phase SHALL toggle every BLINK_DIV cycles.
REQ-026 SHALL, when blink_en falls, show the held value on the next cycle; the display value itself SHALL be unaffected by blinking.

Reset
REQ-027 SHALL, on rst assertion, immediately set ssd to all 7'h7F, in_ready = 0, busy = 0, FSM = IDLE, blink counter = 0 and blink phase = on, including mid-conversion; any pending conversion SHALL be discarded.
REQ-028 SHALL assert in_ready on the first clk edge after rst deasserts.

Structure
REQ-029 SHALL define the segment glyph constants, the minus/blank constants and the FSM state enum in shared package ssd_pkg.
REQ-030 SHALL place the double-dabble datapath (binary shift register, BCD digit registers, add-3 logic) in sub-module ssd_bcd_conv, controlled by the FSM in ssd_bcd_display.

Verification
REQ-031 SHALL cover: hex, in_data = 16'h1A3F -> ssd = {7'h79, 7'h08, 7'h30, 7'h0E} one cycle after the handshake.
REQ-032 SHALL cover: decimal, in_data = 42, blank_lz = 1 -> after exactly 18 cycles ssd = {7'h7F, 7'h7F, 7'h19, 7'h24}; in_ready = 0 throughout the conversion.
REQ-033 SHALL cover: decimal signed, in_data = 16'hFFF9 (-7), blank_lz = 0 -> ssd = {7'h3F, 7'h40, 7'h40, 7'h78}.
REQ-034 SHALL cover: decimal unsigned 12345 -> all four digits 7'h3F; decimal signed -1000 -> all four digits 7'h3F.
REQ-035 SHALL cover: rst pulsed during SHIFT cycle 5 -> ssd = all 7'h7F in the same cycle, in_ready = 1 one edge after release, and the previous value is never shown.
REQ-036 SHALL cover: BLINK_DIV = 4, blink_en = 1 -> ssd alternates between the value and 7'h7F every 4 cycles; a second in_valid held during busy is accepted exactly on the cycle IDLE is re-entered.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment BCD display.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    // Nibble to active-low segment pattern.
    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ssd_bcd_conv.sv
// Double-dabble (shift-add-3) binary to BCD datapath, one input bit per shift.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : load data_i into the shift register and clear the BCD digits
//   shift_i      : perform one add-3 / shift step
//   data_i       : binary magnitude to convert
//   bcd_o        : BCD digits, digit 0 in bcd_o[3:0]
module ssd_bcd_conv #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BCD_DIGITS = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic                      shift_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    output logic [4*BCD_DIGITS-1:0]   bcd_o
);

    localparam int unsigned BCDW = 4 * BCD_DIGITS;

    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [BCDW-1:0]       bcd_q, bcd_d;
    logic [BCDW-1:0]       adj;

    // Add 3 to every digit >= 5 so the following shift carries correctly.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        if (load_i) begin
            bin_d = data_i;
            bcd_d = '0;
        end else if (shift_i) begin
            bcd_d = {adj[BCDW-2:0], bin_q[DATA_WIDTH-1]};
            bin_d = {bin_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/ssd_bcd_display.sv
// Multi-digit seven-segment display driver: hex or decimal (optionally signed),
// leading-zero blanking, overflow indication and whole-display blinking.
// Ports:
//   clk, rst   : clock, async active-high reset
//   in_valid   : value offered;  in_ready : block can accept (IDLE only)
//   in_data    : value;  in_mode : 0 hex / 1 decimal;  in_signed : two's complement
//   blank_lz   : blank leading zeros;  blink_en : blink whole display
//   ssd        : active-low segments, digit 0 in ssd[6:0]
//   busy       : decimal conversion in progress
module ssd_bcd_display
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_mode,
    input  logic                    in_signed,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [7*NUM_DIGITS-1:0] ssd,
    output logic                    busy
);

    localparam int unsigned BCD_DIGITS = (DATA_WIDTH * 3) / 10 + 1;
    localparam int unsigned BCDW       = 4 * BCD_DIGITS;
    localparam int unsigned NIBW       = 4 * NUM_DIGITS;
    localparam int unsigned SSDW       = 7 * NUM_DIGITS;
    localparam int unsigned CNTW       = $clog2(DATA_WIDTH);
    localparam int unsigned BLW        = $clog2(BLINK_DIV + 1);

    state_e                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  neg_q, neg_d;
    logic                  blank_q, blank_d;
    logic [SSDW-1:0]       disp_q, disp_d;
    logic [SSDW-1:0]       ssd_q, ssd_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic [BLW-1:0]        blink_cnt_q, blink_cnt_d;
    logic                  blink_on_q, blink_on_d;

    logic                  conv_load, conv_shift;
    logic [DATA_WIDTH:0]   mag;
    logic                  mag_msb_unused;
    logic [DATA_WIDTH-1:0] conv_data;
    logic [BCDW-1:0]       bcd;
    logic                  dec_ovf;
    logic [SSDW-1:0]       hex_word, dec_word;

    // Render NUM_DIGITS nibbles, optionally with a minus in the top digit and
    // leading zeros blanked; digit 0 is always drawn.
    function automatic logic [SSDW-1:0] format_digits(input logic [NIBW-1:0] nibs,
                                                      input logic neg,
                                                      input logic blank);
        logic [SSDW-1:0] word;
        logic            seen;
        word = '0;
        seen = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (nibs[4*i +: 4] != 4'd0) seen = 1'b1;
            if (neg && i == int'(NUM_DIGITS) - 1) begin
                word[7*i +: 7] = SEG_MINUS;
            end else if (blank && !seen && i != 0) begin
                word[7*i +: 7] = SEG_BLANK;
            end else begin
                word[7*i +: 7] = seg_glyph(nibs[4*i +: 4]);
            end
        end
        return word;
    endfunction

    // Magnitude is formed one bit wider so the most negative input negates correctly;
    // its top bit is always zero and is not needed by the converter.
    always_comb begin
        mag = neg_q ? -{1'b1, data_q} : {1'b0, data_q};
    end
    assign {mag_msb_unused, conv_data} = mag;

    ssd_bcd_conv #(
        .DATA_WIDTH (DATA_WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_conv (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (conv_load),
        .shift_i (conv_shift),
        .data_i  (conv_data),
        .bcd_o   (bcd)
    );

    // Overflow when a nonzero digit lands outside the available digits
    // (one fewer when the top digit carries the minus sign).
    always_comb begin
        dec_ovf = 1'b0;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd[4*i +: 4] != 4'd0 &&
                (i >= int'(NUM_DIGITS) || (neg_q && i >= int'(NUM_DIGITS) - 1))) begin
                dec_ovf = 1'b1;
            end
        end
    end

    assign hex_word = format_digits(NIBW'(in_data), 1'b0, blank_lz);
    assign dec_word = dec_ovf ? {NUM_DIGITS{SEG_MINUS}}
                              : format_digits(NIBW'(bcd), neg_q, blank_q);

    // FSM next state, capture, blink timebase and output staging.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        neg_d       = neg_q;
        blank_d     = blank_q;
        disp_d      = disp_q;
        conv_load   = 1'b0;
        conv_shift  = 1'b0;
        blink_cnt_d = blink_cnt_q + BLW'(1);
        blink_on_d  = blink_on_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (in_mode) begin
                        data_d  = in_data;
                        neg_d   = in_signed & in_data[DATA_WIDTH-1];
                        blank_d = blank_lz;
                        state_d = LOAD;
                    end else begin
                        disp_d = hex_word;
                    end
                end
            end
            LOAD: begin
                conv_load = 1'b1;
                cnt_d     = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                conv_shift = 1'b1;
                cnt_d      = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(DATA_WIDTH - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = dec_word;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (blink_cnt_q == BLW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        // A decimal result goes straight to the output on the COMMIT edge.
        if (blink_en && !blink_on_q) begin
            ssd_d = {NUM_DIGITS{SEG_BLANK}};
        end else if (state_q == COMMIT) begin
            ssd_d = dec_word;
        end else begin
            ssd_d = disp_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            neg_q       <= 1'b0;
            blank_q     <= 1'b0;
            disp_q      <= {NUM_DIGITS{SEG_BLANK}};
            ssd_q       <= {NUM_DIGITS{SEG_BLANK}};
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            neg_q       <= neg_d;
            blank_q     <= blank_d;
            disp_q      <= disp_d;
            ssd_q       <= ssd_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign ssd      = ssd_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ssd_bcd_display.sv
// Self-checking bench for ssd_bcd_display (4 digits, 16-bit data, BLINK_DIV = 4).
module tb_ssd_bcd_display;

    localparam logic [27:0] BLANK4 = {4{7'h7F}};
    localparam logic [27:0] MINUS4 = {4{7'h3F}};
    localparam logic [6:0]  GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic        in_signed = 1'b0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [27:0] ssd;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_hs = 0;
    int id_cnt = 0;

    typedef struct {
        logic [27:0] word;
        int          due;
        int          hs;
        bit          dec;
        int          id;
    } exp_t;

    exp_t sb[$];

    ssd_bcd_display #(
        .NUM_DIGITS (4),
        .DATA_WIDTH (16),
        .BLINK_DIV  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_signed (in_signed),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .ssd       (ssd),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Arithmetic reference: hex nibbles or decimal digits via div/mod.
    function automatic logic [27:0] model(input logic [15:0] d, input logic m,
                                          input logic s, input logic b);
        int          v;
        bit          neg;
        int          dig [4];
        logic [27:0] w;
        bit          seen;
        neg = 1'b0;
        v   = 0;
        if (!m) begin
            for (int i = 0; i < 4; i++) dig[i] = int'((d >> (4 * i)) & 16'hF);
        end else begin
            neg = s && d[15];
            v   = neg ? -int'($signed(d)) : int'(d);
            if (v >= (neg ? 1000 : 10000)) return MINUS4;
            for (int i = 0; i < 4; i++) begin
                dig[i] = v % 10;
                v      = v / 10;
            end
        end
        w    = '0;
        seen = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (dig[i] != 0) seen = 1'b1;
            if (neg && i == 3)                 w[7*i +: 7] = 7'h3F;
            else if (b && !seen && i != 0)     w[7*i +: 7] = 7'h7F;
            else                               w[7*i +: 7] = GLY[dig[i]];
        end
        return w;
    endfunction

    // Offer a value, wait (bounded) for acceptance, and queue its expected display.
    task automatic send(input logic [15:0] d, input logic m, input logic s, input logic b,
                        input logic [27:0] exp, input bit track, input bit hold);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        in_signed = s;
        blank_lz  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        last_hs = cyc + 1;
        if (track) begin
            sb.push_back('{word: exp, due: cyc + 1 + (m ? 18 : 1), hs: cyc + 1, dec: m, id: id_cnt});
            id_cnt++;
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: compare ssd on the due cycle; while a conversion runs, in_ready low and busy high.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (cyc == sb[0].due) begin
                check($sformatf("ssd_out%0d", sb[0].id), 32'(ssd), 32'(sb[0].word));
                void'(sb.pop_front());
            end else if (sb[0].dec && cyc > sb[0].hs) begin
                check("conv_ready_busy", {30'b0, in_ready, busy}, 32'd1);
            end
        end
    end

    initial begin
        int          hs1;
        int          n;
        int          bad;
        logic [27:0] prev;
        logic [27:0] val;
        logic [15:0] d;
        logic        m, s, b;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ssd", 32'(ssd), 32'(BLANK4));
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        send(16'h1A3F, 1'b0, 1'b0, 1'b0, {7'h79, 7'h08, 7'h30, 7'h0E}, 1'b1, 1'b0);
        send(16'd42,   1'b1, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b1, 1'b0);
        send(16'hFFF9, 1'b1, 1'b1, 1'b0, {7'h3F, 7'h40, 7'h40, 7'h78}, 1'b1, 1'b0);
        send(16'd12345, 1'b1, 1'b0, 1'b0, MINUS4, 1'b1, 1'b0);
        send(16'hFC18, 1'b1, 1'b1, 1'b0, MINUS4, 1'b1, 1'b0);
        send(16'd0,    1'b1, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b1, 1'b0);
        send(16'd9999, 1'b1, 1'b0, 1'b1, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b1, 1'b0);
        send(16'hFC19, 1'b1, 1'b1, 1'b1, {7'h3F, 7'h10, 7'h10, 7'h10}, 1'b1, 1'b0);
        send(16'hFFFB, 1'b1, 1'b1, 1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h12}, 1'b1, 1'b0);
        send(16'h8000, 1'b1, 1'b1, 1'b0, MINUS4, 1'b1, 1'b0);
        send(16'h8000, 1'b1, 1'b0, 1'b0, MINUS4, 1'b1, 1'b0);
        send(16'h00F0, 1'b0, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h0E, 7'h40}, 1'b1, 1'b0);
        send(16'hFFFF, 1'b0, 1'b1, 1'b0, {4{7'h0E}}, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            d = 16'($urandom);
            if (k % 3 == 0) d = 16'($urandom_range(0, 1200));
            m = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            send(d, m, s, b, model(d, m, s, b), 1'b1, 1'b0);
        end
        drain();

        // Offer held through a conversion is taken on the edge IDLE returns.
        send(16'd321, 1'b1, 1'b0, 1'b0, {7'h40, 7'h30, 7'h24, 7'h79}, 1'b1, 1'b1);
        hs1 = last_hs;
        send(16'hBEEF, 1'b0, 1'b0, 1'b0, {7'h03, 7'h06, 7'h06, 7'h0E}, 1'b1, 1'b0);
        check("accept_on_idle", 32'(last_hs - hs1), 32'd19);
        drain();

        // Reset in the fifth SHIFT cycle discards the conversion.
        send(16'd4321, 1'b1, 1'b0, 1'b0, 28'h0, 1'b0, 1'b0);
        n = 0;
        while (cyc < last_hs + 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_ssd", 32'(ssd), 32'({7'h03, 7'h06, 7'h06, 7'h0E}));
        rst = 1'b1;
        #1;
        check("mid_rst_ssd", 32'(ssd), 32'(BLANK4));
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_rst", 32'(in_ready), 32'd1);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (ssd !== BLANK4 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("no_stale_value", 32'(bad), 32'd0);

        // Blinking: 4 cycles on, 4 cycles off, release restores the value next cycle.
        val = {7'h79, 7'h24, 7'h30, 7'h19};
        send(16'h1234, 1'b0, 1'b0, 1'b0, val, 1'b1, 1'b0);
        drain();
        @(negedge clk);
        blink_en = 1'b1;
        prev = ssd;
        n = 0;
        @(negedge clk);
        while (!(prev === BLANK4 && ssd === val) && n < 30) begin
            prev = ssd;
            @(negedge clk);
            n++;
        end
        check("blink_start", 32'(ssd), 32'(val));
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("blink_k%0d", k), 32'(ssd), 32'(((k / 4) % 2 == 0) ? val : BLANK4));
        end
        blink_en = 1'b0;
        @(negedge clk);
        check("blink_release", 32'(ssd), 32'(val));
        repeat (5) @(negedge clk);
        check("value_held", 32'(ssd), 32'(val));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
